// File: rtl/mux_arb_pkg.sv
// Shared types, widths and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin winner pick among 4 requesters, lowest priority at ptr.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
// Rotate so ptr+1 sits at bit 0, fixed-priority pick, then un-rotate.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] base;
  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] off;

  assign base = ptr + SEL_W'(1);
  assign any  = |req;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[base + SEL_W'(i)];
    end
  end

  // Descending scan so the lowest rotated index wins.
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign win = base + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the 4:1 mux selects and one-hot grant.
// Latency: req in cycle t -> gnt/selects in t+1; one IDLE bubble after each release.
// Backpressure: ready low stalls beats and holds the grant while the owner keeps req.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  input  logic            ready,
  output logic [NREQ-1:0] gnt,
  output logic            s1,
  output logic            s0,
  output logic            busy,
  output logic            fire,
  output logic            preempt
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic             HOLD_EN   = (MAX_HOLD != 0);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic             preempt_nxt;

  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             owner_req, owner_last;
  logic             rel_last, rel_drop, rel_hold, release_now;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .win (pick_win)
  );

  assign owner_req  = req[ptr];
  assign owner_last = last[ptr];
  assign busy       = (state == ST_GRANT);
  assign fire       = busy & owner_req & ready;

  assign rel_last    = fire & owner_last;
  assign rel_drop    = busy & ~owner_req;
  assign rel_hold    = HOLD_EN & fire & (beat_cnt == HOLD_LAST);
  assign release_now = rel_last | rel_drop | rel_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= SEL_W'(NREQ - 1);
      beat_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= cnt_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      preempt  <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any)    state_nxt = ST_GRANT;
      ST_GRANT: if (release_now) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Selects keep their last value in IDLE so the mux output does not toggle.
  always_comb begin
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    ptr_nxt     = ptr;
    cnt_nxt     = beat_cnt;
    preempt_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_nxt = '0;
        if (pick_any) begin
          gnt_nxt = onehot2(pick_win);
          sel_nxt = pick_win;
          ptr_nxt = pick_win;
          cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (fire && beat_cnt != CNT_MAX) cnt_nxt = beat_cnt + CNT_W'(1);
        if (release_now) begin
          gnt_nxt     = '0;
          preempt_nxt = rel_hold & ~rel_last;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

endmodule
